// File: rtl/tt_mult_pkg.sv
// -----------------------------------------------------------------------------
// tt_mult_pkg
// Shared constants and types for the ternary matrix-vector multiply sequencer.
// The matrix is IN_LEN x OUT_LEN with 2-bit weights, loaded W_BEAT_W bits per
// beat. Activations are consumed two per accumulation beat.
// -----------------------------------------------------------------------------
package tt_mult_pkg;

  localparam int IN_LEN    = 14;  // activations per input vector (even)
  localparam int OUT_LEN   = 7;   // results per output vector
  localparam int BIT_WIDTH = 8;   // activation / result width
  localparam int W_BEAT_W  = 8;   // weight bits per load beat

  localparam int NUM_BEATS = IN_LEN / 2;
  localparam int W_BITS    = 2 * IN_LEN * OUT_LEN;
  localparam int W_BEATS   = (W_BITS + W_BEAT_W - 1) / W_BEAT_W;

  localparam int WCNT_W = $clog2(W_BEATS);
  localparam int BCNT_W = $clog2(NUM_BEATS);
  // One extra code so the select counter can run one past the last result.
  localparam int SEL_W  = $clog2(OUT_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_SETTLE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/tt_mult_sequencer_wload.sv
// -----------------------------------------------------------------------------
// tt_weight_loader
// Holds the packed ternary weight matrix and writes one W_BEAT_W-bit beat per
// wr_en at bit offset W_BEAT_W*wr_idx. Bits of the final beat that fall past
// the end of the matrix are dropped.
// Ports:
//   clk, rst_n  clock / async active-low reset (matrix clears to all-zero)
//   wr_en       write the beat this cycle
//   wr_idx      beat index
//   w_data      beat data, 2 bits per weight, LSB-first
//   dp_w        full weight matrix
// -----------------------------------------------------------------------------
module tt_weight_loader
  import tt_mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [WCNT_W-1:0]   wr_idx,
  input  logic [W_BEAT_W-1:0] w_data,
  output logic [W_BITS-1:0]   dp_w
);

  // One register slice per beat; the last slice is only as wide as the bits
  // that remain, which is what discards the tail of the final beat.
  for (genvar b = 0; b < W_BEATS; b++) begin : g_beat
    localparam int LO = b * W_BEAT_W;
    localparam int NB = ((W_BITS - LO) < W_BEAT_W) ? (W_BITS - LO) : W_BEAT_W;

    logic [NB-1:0] r_slice;

    // NOTE: this storage is reset because an all-zero matrix is the defined
    // post-reset contents; plain data arrays without that need stay unreset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slice <= '0;
      end else if (wr_en && (wr_idx == WCNT_W'(b))) begin
        r_slice <= w_data[NB-1:0];
      end
    end

    assign dp_w[LO +: NB] = r_slice;
  end

endmodule

// File: rtl/tt_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tt_mult_sequencer
// Controller for the ternary matrix-vector multiply datapath. Loads the weight
// matrix byte-serially, feeds activation pairs to the datapath one accumulate
// step per beat, then drains OUT_LEN results through a valid/ready stream.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   ena                  global enable, low freezes every register
//   cfg_load             start a weight load (seen in IDLE only)
//   w_data, w_valid      weight beat, no backpressure
//   in_data/valid/ready  activation pair stream {a[2k+1], a[2k]}
//   dp_w                 weight matrix to the datapath
//   dp_vec               registered activation pair to the datapath
//   dp_acc_en, dp_clear  accumulate strobe; clear marks the first beat
//   dp_sel, dp_result    result select and selected accumulator
//   out_data/valid/ready result stream
//   busy                 controller is not idle
// -----------------------------------------------------------------------------
module tt_mult_sequencer
  import tt_mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   cfg_load,
  input  logic [W_BEAT_W-1:0]    w_data,
  input  logic                   w_valid,
  input  logic [2*BIT_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W_BITS-1:0]      dp_w,
  output logic [2*BIT_WIDTH-1:0] dp_vec,
  output logic                   dp_acc_en,
  output logic                   dp_clear,
  output logic [SEL_W-1:0]       dp_sel,
  input  logic [BIT_WIDTH-1:0]   dp_result,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  state_t                 r_state, w_next;
  logic [WCNT_W-1:0]      r_wcnt;
  logic [BCNT_W-1:0]      r_bcnt;
  logic [SEL_W-1:0]       r_osel;
  logic [2*BIT_WIDTH-1:0] r_vec;
  logic                   r_acc_en;
  logic                   r_clear;
  logic [BIT_WIDTH-1:0]   r_out_data;
  logic                   r_out_valid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_wr_en;
  logic w_last_beat;
  logic w_last_wbeat;
  logic w_last_out;

  assign w_in_fire    = in_ready && in_valid;
  assign w_out_fire   = ena && r_out_valid && out_ready;
  assign w_wr_en      = ena && (r_state == ST_LOAD) && w_valid;
  assign w_last_beat  = (r_bcnt == BCNT_W'(NUM_BEATS - 1));
  assign w_last_wbeat = (r_wcnt == WCNT_W'(W_BEATS - 1));
  // r_osel runs one ahead of the presented result: it selects the next result
  // to fetch, so reaching OUT_LEN means the last result is on out_data.
  assign w_last_out   = (r_osel == SEL_W'(OUT_LEN));

  // NOTE: every registered signal uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: defaults come first so every path assigns every output, which keeps
  // this block purely combinational.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_load)      w_next = ST_LOAD;
          else if (in_valid) w_next = ST_ACCUM;
        end
        ST_LOAD: begin
          if (w_valid && w_last_wbeat) w_next = ST_IDLE;
        end
        ST_ACCUM: begin
          in_ready = 1'b1;
          if (in_valid && w_last_beat) w_next = ST_SETTLE;
        end
        ST_SETTLE: w_next = ST_DRAIN;
        ST_DRAIN: begin
          if (w_out_fire && w_last_out) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Activation path and weight-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_acc_en <= 1'b0;
      r_clear  <= 1'b0;
      r_bcnt   <= '0;
      r_wcnt   <= '0;
    end else if (ena) begin
      r_acc_en <= w_in_fire;
      r_clear  <= w_in_fire && (r_bcnt == '0);
      if (w_in_fire) begin
        r_vec  <= in_data;
        r_bcnt <= w_last_beat ? '0 : r_bcnt + 1'b1;
      end
      if ((r_state == ST_IDLE) && cfg_load) begin
        r_wcnt <= '0;
      end else if (w_wr_en) begin
        r_wcnt <= w_last_wbeat ? '0 : r_wcnt + 1'b1;
      end
    end
  end

  // Result drain. The first DRAIN cycle fetches result 0 with out_valid low;
  // after that each transfer fetches the next result in the same cycle, so
  // out_valid stays high across the whole vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_osel      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (ena) begin
      if (r_state == ST_SETTLE) begin
        r_osel <= '0;
      end else if (r_state == ST_DRAIN) begin
        if (!r_out_valid) begin
          r_out_data  <= dp_result;
          r_out_valid <= 1'b1;
          r_osel      <= r_osel + 1'b1;
        end else if (out_ready) begin
          if (w_last_out) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_data <= dp_result;
            r_osel     <= r_osel + 1'b1;
          end
        end
      end
    end
  end

  tt_weight_loader u_wload (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_wr_en),
    .wr_idx (r_wcnt),
    .w_data (w_data),
    .dp_w   (dp_w)
  );

  // The accumulate strobe is held through a stall, so it is masked by ena to
  // make the datapath add each pair exactly once, on the first enabled cycle.
  assign dp_acc_en = r_acc_en && ena;
  assign dp_clear  = r_clear && ena;
  assign dp_vec    = r_vec;
  assign dp_sel    = r_osel;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tt_mult_sequencer.sv
module tb_tt_mult_sequencer;
  import tt_mult_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ena = 1'b0;
  logic                   cfg_load = 1'b0;
  logic [W_BEAT_W-1:0]    w_data = '0;
  logic                   w_valid = 1'b0;
  logic [2*BIT_WIDTH-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   in_ready, dp_acc_en, dp_clear, out_valid, busy;
  logic [W_BITS-1:0]      dp_w;
  logic [2*BIT_WIDTH-1:0] dp_vec;
  logic [SEL_W-1:0]       dp_sel;
  logic [BIT_WIDTH-1:0]   dp_result, out_data;

  always #5 clk = ~clk;

  tt_mult_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_load(cfg_load),
    .w_data(w_data), .w_valid(w_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dp_w(dp_w), .dp_vec(dp_vec), .dp_acc_en(dp_acc_en), .dp_clear(dp_clear),
    .dp_sel(dp_sel), .dp_result(dp_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Weight code: 01 = +1, 11 = -1, others = 0; weight (row j, input i) at 2*(j*IN_LEN+i).
  function automatic int wt(input logic [W_BITS-1:0] w, input int j, input int i);
    logic [1:0] c;
    if (i >= IN_LEN || j >= OUT_LEN) return 0;
    c = w[2*(j*IN_LEN+i) +: 2];
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // Behavioural ternary datapath: own step counter, restarted by dp_clear.
  logic [BIT_WIDTH-1:0] m_acc [OUT_LEN];
  int m_step;
  always @(posedge clk or negedge rst_n) begin : dp_model
    int k;
    int s;
    if (!rst_n) begin
      for (int j = 0; j < OUT_LEN; j++) m_acc[j] <= '0;
      m_step <= 0;
    end else if (dp_acc_en) begin
      k = dp_clear ? 0 : m_step;
      for (int j = 0; j < OUT_LEN; j++) begin
        s = (dp_clear ? 0 : int'($signed(m_acc[j])))
          + wt(dp_w, j, 2*k)   * int'($signed(dp_vec[7:0]))
          + wt(dp_w, j, 2*k+1) * int'($signed(dp_vec[15:8]));
        m_acc[j] <= BIT_WIDTH'(s);
      end
      m_step <= k + 1;
    end
  end
  assign dp_result = (dp_sel < SEL_W'(OUT_LEN)) ? m_acc[dp_sel] : '0;

  // Bench-side state: expected weights, stimulus vectors, scoreboard.
  logic [W_BITS-1:0]    tb_w = '0;
  logic [7:0]           wbytes [W_BEATS];
  logic [7:0]           vec_a  [IN_LEN];
  logic [BIT_WIDTH-1:0] sb_q [$];
  bit                   rand_mode = 1'b0;

  // ena / out_ready: fixed high, or random when rand_mode is set.
  always @(negedge clk) begin
    if (rand_mode) begin
      ena       = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
    end else begin
      ena       = 1'b1;
      out_ready = 1'b1;
    end
  end

  // Output monitor: pops on each transfer, checks hold behaviour under stall.
  logic                 mon_hold = 1'b0;
  logic [BIT_WIDTH-1:0] mon_data = '0;
  always @(negedge clk) begin : monitor
    logic [BIT_WIDTH-1:0] e;
    #1;
    if (!rst_n) begin
      mon_hold = 1'b0;
    end else begin
      if (mon_hold) begin
        check("out_valid_held", out_valid, 1'b1);
        check("out_data_stable", out_data, mon_data);
      end
      if (ena && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("extra_output_queue_size", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e);
        end
      end
      mon_hold = out_valid && !(ena && out_ready);
      mon_data = out_data;
    end
  end

  task automatic push_model();
    for (int j = 0; j < OUT_LEN; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < IN_LEN; i++) s += wt(tb_w, j, i) * int'($signed(vec_a[i]));
      sb_q.push_back(BIT_WIDTH'(s));
    end
  endtask

  task automatic start_load();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      cfg_load = 1'b1;
      #1;
      done = ena;
    end
    check("load_start_accepted", done, 1'b1);
  endtask

  task automatic feed_bytes(input int n);
    int i;
    i = 0;
    for (int c = 0; c < 2000 && i < n; c++) begin
      @(negedge clk);
      cfg_load = 1'b0;
      in_valid = 1'b0;
      w_valid  = 1'b1;
      w_data   = wbytes[i];
      #1;
      if (ena) begin
        for (int k = 0; k < W_BEAT_W; k++)
          if (i*W_BEAT_W + k < W_BITS) tb_w[i*W_BEAT_W + k] = wbytes[i][k];
        i++;
      end
    end
    check("load_bytes_accepted", i, n);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_vector(input bit gaps, input bit hold_cfg, input bit lat_chk);
    int k;
    k = 0;
    for (int c = 0; c < 4000 && k < NUM_BEATS; c++) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = {vec_a[2*k+1], vec_a[2*k]};
      cfg_load = hold_cfg && busy;
      #1;
      if (in_valid && in_ready) k++;
    end
    check("vector_beats_accepted", k, NUM_BEATS);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    if (lat_chk) begin
      check("latency_t1_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("latency_t2_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("latency_t3_out_valid", out_valid, 1'b1);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      #2;
      done = (sb_q.size() == 0) && !busy;
    end
    check("drain_complete", done, 1'b1);
  endtask

  typedef struct {
    logic [7:0] w_byte;
    logic [7:0] act;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [3];

  initial begin
    tbl[0] = '{w_byte: 8'h55, act: 8'd1,  exp: 8'd14};
    tbl[1] = '{w_byte: 8'hFF, act: 8'd3,  exp: 8'hD6};
    tbl[2] = '{w_byte: 8'h55, act: 8'd10, exp: 8'h8C};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dp_w", dp_w, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_dp_acc_en", dp_acc_en, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_dp_sel", dp_sel, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a load, then a full load.
    for (int b = 0; b < W_BEATS; b++) wbytes[b] = 8'h55;
    start_load();
    feed_bytes(10);
    check("mid_load_busy", busy, 1'b1);
    check("mid_load_partial_weights", dp_w, tb_w);
    rst_n = 1'b0;
    tb_w  = '0;
    #1;
    check("mid_load_rst_dp_w", dp_w, '0);
    check("mid_load_rst_busy", busy, 1'b0);
    check("mid_load_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_load();
    feed_bytes(W_BEATS);
    check("reload_weights", dp_w, tb_w);
    check("reload_busy", busy, 1'b0);

    // Table-driven vectors with constant weights and inputs.
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < W_BEATS; b++) wbytes[b] = tbl[t].w_byte;
      start_load();
      feed_bytes(W_BEATS);
      for (int i = 0; i < IN_LEN; i++) vec_a[i] = tbl[t].act;
      for (int j = 0; j < OUT_LEN; j++) sb_q.push_back(tbl[t].exp);
      send_vector(1'b0, 1'b0, t == 0);
      wait_idle();
    end

    // Back-to-back vectors: the second must restart accumulation from zero.
    for (int i = 0; i < IN_LEN; i++) vec_a[i] = 8'(i + 1);
    push_model();
    send_vector(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < IN_LEN; i++) vec_a[i] = 8'hFE;
    push_model();
    send_vector(1'b0, 1'b0, 1'b0);
    wait_idle();

    // cfg_load held during ACCUM is ignored.
    for (int i = 0; i < IN_LEN; i++) vec_a[i] = 8'($urandom);
    push_model();
    send_vector(1'b0, 1'b1, 1'b0);
    wait_idle();
    check("cfg_in_accum_weights_kept", dp_w, tb_w);

    // cfg_load and in_valid together in IDLE: load wins.
    @(negedge clk);
    cfg_load = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0101;
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    #1;
    check("prio_busy", busy, 1'b1);
    check("prio_in_ready_low", in_ready, 1'b0);
    for (int b = 0; b < W_BEATS; b++) wbytes[b] = 8'($urandom);
    feed_bytes(W_BEATS);
    check("prio_new_weights", dp_w, tb_w);

    // Random weights, data, input gaps, output stalls and ena toggling.
    rand_mode = 1'b1;
    for (int v = 0; v < 3; v++) begin
      wait_idle();
      for (int b = 0; b < W_BEATS; b++) wbytes[b] = 8'($urandom);
      start_load();
      feed_bytes(W_BEATS);
      check("rand_weights", dp_w, tb_w);
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < IN_LEN; i++) vec_a[i] = 8'($urandom);
        push_model();
        send_vector(1'b1, 1'b0, 1'b0);
      end
    end
    wait_idle();
    rand_mode = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
